// File: rtl/pkt_out_arbiter.sv
// Two-source packet merger: each source feeds its own FIFO through an
// admission/truncation front end, and a round-robin FSM drains whole packets
// onto a single registered output with at least one idle cycle between packets.

// Per-source ingress: packet admission, truncation, drop counting and FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | between packets, waiting for a head word
// ST_IN_PKT  | head accepted, writing words until tail or truncation
// ST_DROP    | discarding words until the next tail word
module pkt_out_ingress #(
   parameter int DEPTH         = 64,
   parameter int AW            = 6,
   parameter int MAX_PKT_WORDS = 32,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [133:0]     in_data,
   input  logic             pop,
   output logic [133:0]     head_word,
   output logic             pkt_avail,
   output logic             nonempty,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int WC_W = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [AW:0] USED_LIMIT = (AW+1)'(DEPTH - MAX_PKT_WORDS);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_PKT_WORDS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DROP} ing_state_t;

   ing_state_t        state, state_nx;
   logic [WC_W-1:0]   wc, wc_nx;
   logic [133:0]      mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       used, pkt_cnt;
   logic              wr_en, wr_tail, drop_inc, rd_tail;
   logic [133:0]      wr_word;
   logic              is_head, is_tail, has_room;

   assign is_head   = in_data[132];
   assign is_tail   = in_data[133];
   // Admission looks at occupancy before this cycle's write and pop.
   assign has_room  = (used <= USED_LIMIT);
   assign head_word = mem[rd_ptr];
   assign rd_tail   = pop & head_word[133];
   assign pkt_avail = (pkt_cnt != '0);
   assign nonempty  = (used != '0);

   // Ingress state register and word count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         wc    <= '0;
      end else begin
         state <= state_nx;
         wc    <= wc_nx;
      end
   end

   // Ingress decisions: what to write, when to drop, next state.
   always_comb begin
      state_nx = state;
      wc_nx    = wc;
      wr_en    = 1'b0;
      wr_tail  = 1'b0;
      wr_word  = in_data;
      drop_inc = 1'b0;
      if (in_valid) begin
         case (state)
            ST_IDLE: begin
               if (is_head) begin
                  if (has_room) begin
                     wr_en = 1'b1;
                     if (is_tail) begin
                        wr_tail = 1'b1;
                     end else begin
                        state_nx = ST_IN_PKT;
                        wc_nx    = WC_W'(1);
                     end
                  end else begin
                     drop_inc = 1'b1;
                     if (!is_tail) state_nx = ST_DROP;
                  end
               end
            end
            ST_IN_PKT: begin
               // A stray head abandons the open packet; its words stay in the
               // FIFO untouched and are flushed along with the next packet.
               if (is_head) begin
                  drop_inc = 1'b1;
                  state_nx = is_tail ? ST_IDLE : ST_DROP;
               end else if (is_tail) begin
                  wr_en    = 1'b1;
                  wr_tail  = 1'b1;
                  state_nx = ST_IDLE;
               end else if (wc == WC_LAST) begin
                  wr_en              = 1'b1;
                  wr_word[133:132]   = 2'b10;
                  wr_tail            = 1'b1;
                  drop_inc           = 1'b1;
                  state_nx           = ST_DROP;
               end else begin
                  wr_en = 1'b1;
                  wc_nx = wc + WC_W'(1);
               end
            end
            ST_DROP: begin
               if (is_tail) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // FIFO storage; contents are don't-care once pointers reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_word;
   end

   // FIFO pointers, occupancy, complete-packet count and drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         used     <= '0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   used <= used + (AW+1)'(1);
            2'b01:   used <= used - (AW+1)'(1);
            default: used <= used;
         endcase
         case ({wr_tail, rd_tail})
            2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
            2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// Round-robin packet arbiter.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no packet in flight; pick a source with a complete packet
// SEND0  | popping one word per cycle from source 0 until its tail
// SEND1  | popping one word per cycle from source 1 until its tail
module pkt_out_arbiter #(
   parameter int DEPTH         = 64,
   parameter int AW            = 6,
   parameter int MAX_PKT_WORDS = 32,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [133:0]     in0_data,
   input  logic             in1_valid,
   input  logic [133:0]     in1_data,
   output logic             data_out_valid,
   output logic [133:0]     data_out,
   output logic [CNT_W-1:0] drop_cnt0,
   output logic [CNT_W-1:0] drop_cnt1,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SEND0, SEND1} arb_state_t;

   arb_state_t    state, state_nx;
   logic          last_grant, last_grant_nx;
   logic          pop0, pop1;
   logic [133:0]  word0, word1;
   logic          avail0, avail1, nonempty0, nonempty1;
   logic          pop_valid;
   logic [133:0]  pop_data;

   pkt_out_ingress #(.DEPTH(DEPTH), .AW(AW), .MAX_PKT_WORDS(MAX_PKT_WORDS), .CNT_W(CNT_W)) u_in0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in0_valid),
      .in_data   (in0_data),
      .pop       (pop0),
      .head_word (word0),
      .pkt_avail (avail0),
      .nonempty  (nonempty0),
      .drop_cnt  (drop_cnt0)
   );

   pkt_out_ingress #(.DEPTH(DEPTH), .AW(AW), .MAX_PKT_WORDS(MAX_PKT_WORDS), .CNT_W(CNT_W)) u_in1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in1_valid),
      .in_data   (in1_data),
      .pop       (pop1),
      .head_word (word1),
      .pkt_avail (avail1),
      .nonempty  (nonempty1),
      .drop_cnt  (drop_cnt1)
   );

   assign busy = nonempty0 | nonempty1 | (state != IDLE) | pop_valid | data_out_valid;

   // Arbiter state and round-robin memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
      end
   end

   // Grant selection and per-cycle pop; a packet ends on its tail word.
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      pop0          = 1'b0;
      pop1          = 1'b0;
      case (state)
         IDLE: begin
            if (avail0 && avail1) begin
               state_nx      = last_grant ? SEND0 : SEND1;
               last_grant_nx = ~last_grant;
            end else if (avail0) begin
               state_nx      = SEND0;
               last_grant_nx = 1'b0;
            end else if (avail1) begin
               state_nx      = SEND1;
               last_grant_nx = 1'b1;
            end
         end
         SEND0: begin
            if (nonempty0) begin
               pop0 = 1'b1;
               if (word0[133]) state_nx = IDLE;
            end
         end
         SEND1: begin
            if (nonempty1) begin
               pop1 = 1'b1;
               if (word1[133]) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Pop stage then output register; data_out holds while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_valid      <= 1'b0;
         pop_data       <= '0;
         data_out_valid <= 1'b0;
         data_out       <= '0;
      end else begin
         pop_valid      <= pop0 | pop1;
         if (pop0)      pop_data <= word0;
         else if (pop1) pop_data <= word1;
         data_out_valid <= pop_valid;
         if (pop_valid) data_out <= pop_data;
      end
   end

endmodule
